// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: execute-stage ALU with built-in ALUOp/funct decode and
// an iterative unsigned shift/add multiplier and a restoring divider.
// The divider is built only when the macro MULDIV_DIV_EN is defined.
// Without it, the divu encoding falls back to a single-cycle add.
//
// Handshake: an op is accepted on a rising edge where start_i = 1 and
// busy_o = 0. While busy_o = 1 the unit ignores start_i and holds its
// operands and code. done_o pulses high for exactly one cycle per accepted
// op, in the cycle in which result_o/zero_o carry that op's result. done_o
// is never high together with busy_o. Starting in the done cycle is allowed
// and gives back-to-back operation.
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       EX_signal_i,
  input  logic [9:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [3:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_DIVU = 4'b1110;
  localparam logic [3:0] ALU_MUL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0]       code_in;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] op_a_q;   // multiplicand (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] op_b_q;   // multiplier (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_q;    // partial product
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mul_acc_nxt;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_q;    // partial remainder, one spare bit for the shift
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] quo_nxt;
`endif

  assign state_o = state_q;

  // Map the ALUOp field and {funct7,funct3} onto a 4-bit ALU code.
  always_comb begin
    code_in = ALU_ADD;
    case (EX_signal_i)
      2'b01: code_in = ALU_SUB;
      2'b10: begin
        case (func_i)
          10'b0000000_111: code_in = ALU_AND;
          10'b0000000_110: code_in = ALU_OR;
          10'b0000000_000: code_in = ALU_ADD;
          10'b0100000_000: code_in = ALU_SUB;
          10'b0000001_000: code_in = ALU_MUL;
`ifdef MULDIV_DIV_EN
          10'b0000001_100: code_in = ALU_DIVU;
`endif
          default:         code_in = ALU_ADD;
        endcase
      end
      default: code_in = ALU_ADD;
    endcase
  end

  // Single-cycle datapath works on the live operands at the accept edge.
  always_comb begin
    alu_res = a_i + b_i;
    case (code_in)
      ALU_AND: alu_res = a_i & b_i;
      ALU_OR:  alu_res = a_i | b_i;
      ALU_SUB: alu_res = a_i - b_i;
      default: alu_res = a_i + b_i;
    endcase
  end

  // One shift-add step. The low half of the product is the same whether the
  // operands are read as signed or unsigned.
  always_comb begin
    mul_acc_nxt = acc_q + (op_b_q[0] ? op_a_q : '0);
  end

`ifdef MULDIV_DIV_EN
  // One restoring-division step. The dividend shifts out MSB-first into the
  // remainder, and the quotient bits shift into the vacated LSBs. A zero
  // divisor always compares as "fits", so the quotient becomes all ones.
  always_comb begin
    rem_sh   = {rem_q[WIDTH-1:0], op_a_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, op_b_q});
    rem_diff = rem_sh - {1'b0, op_b_q};
    quo_nxt  = {op_a_q[WIDTH-2:0], rem_ge};
  end
`endif

  // Control FSM and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      result_o  <= '0;
      ALUCtrl_o <= ALU_AND;
      zero_o    <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`ifdef MULDIV_DIV_EN
      rem_q     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            op_a_q    <= a_i;
            op_b_q    <= b_i;
            ALUCtrl_o <= code_in;
            acc_q     <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            case (code_in)
              ALU_MUL: begin
                state_q <= S_MUL;
                busy_o  <= 1'b1;
              end
`ifdef MULDIV_DIV_EN
              ALU_DIVU: begin
                state_q <= S_DIV;
                busy_o  <= 1'b1;
                rem_q   <= '0;
              end
`endif
              default: begin
                result_o <= alu_res;
                zero_o   <= (alu_res == '0);
                done_o   <= 1'b1;
                state_q  <= S_DONE;
              end
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q  <= mul_acc_nxt;
          op_a_q <= op_a_q << 1;
          op_b_q <= op_b_q >> 1;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_o <= mul_acc_nxt;
            zero_o   <= (mul_acc_nxt == '0);
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state_q  <= S_DONE;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          rem_q  <= rem_ge ? rem_diff : rem_sh;
          op_a_q <= quo_nxt;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_o <= quo_nxt;
            zero_o   <= (quo_nxt == '0);
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state_q  <= S_DONE;
          end
        end
`endif
        default: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Testbench for alu_muldiv_unit. Directed vectors with hand-computed
// results. Expected results are queued when an op is issued, and a monitor
// checks them when done_o is seen. Expectations follow MULDIV_DIV_EN.
module tb_alu_muldiv_unit;

  localparam int W = 32;

  localparam logic [9:0] FN_AND = 10'b0000000_111;
  localparam logic [9:0] FN_OR  = 10'b0000000_110;
  localparam logic [9:0] FN_ADD = 10'b0000000_000;
  localparam logic [9:0] FN_SUB = 10'b0100000_000;
  localparam logic [9:0] FN_MUL = 10'b0000001_000;
  localparam logic [9:0] FN_DIV = 10'b0000001_100;
  localparam logic [9:0] FN_BAD = 10'b1111111_111;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   ex;
  logic [9:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  logic [3:0]   ctrl_q[$];
  int           cyc_q[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .EX_signal_i (ex),
    .func_i      (func),
    .a_i         (a),
    .b_i         (b),
    .ALUCtrl_o   (alu_ctrl),
    .result_o    (result),
    .zero_o      (zero),
    .busy_o      (busy),
    .done_o      (done),
    .state_o     (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pop and compare whenever the DUT reports done
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        logic [W-1:0] er;
        logic [3:0]   ec;
        int           edc;
        er  = exp_q.pop_front();
        ec  = ctrl_q.pop_front();
        edc = cyc_q.pop_front();
        check("result", result, er);
        check("zero", W'(zero), W'(er == '0));
        check("ctrl", W'(alu_ctrl), W'(ec));
        check("latency_cycle", W'(cyc), W'(edc));
        check("busy_with_done", W'(busy), '0);
      end
    end
  end

  // driver: present one request for one cycle (call at a negedge)
  task automatic issue(input logic [1:0] e, input logic [9:0] f,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic [3:0] ec,
                       input int lat, input bit push);
    ex    = e;
    func  = f;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(er);
      ctrl_q.push_back(ec);
      cyc_q.push_back(cyc + lat);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_timeout: got %0d pending ops expected 0", exp_q.size());
      exp_q.delete();
      ctrl_q.delete();
      cyc_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    rst = 1'b1; start = 1'b0; ex = 2'b00; func = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, '0);
    check("rst_ctrl", W'(alu_ctrl), '0);
    check("rst_zero", W'(zero), 1);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_state", W'(state_dbg), '0);
    rst = 1'b0;
    @(negedge clk);

    // single-cycle ops
    issue(2'b10, FN_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1, 1);
    check("and_busy", W'(busy), '0);
    wait_done();
    issue(2'b01, FN_ADD, 32'h0000_1234, 32'h0000_1234, 32'h0, 4'b0110, 1, 1);
    wait_done();
    issue(2'b00, FN_MUL, 32'd5, 32'd7, 32'd12, 4'b0010, 1, 1);
    wait_done();
    issue(2'b11, FN_SUB, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b0010, 1, 1);
    wait_done();
    issue(2'b10, FN_OR, 32'hA0A0_0000, 32'h0000_0505, 32'hA0A0_0505, 4'b0001, 1, 1);
    wait_done();
    issue(2'b10, FN_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b0110, 1, 1);
    wait_done();
    issue(2'b10, FN_BAD, 32'd40, 32'd2, 32'd42, 4'b0010, 1, 1);
    wait_done();

    // mul with busy window and an ignored start at cycle 10
    issue(2'b10, FN_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 4'b1111, W + 1, 1);
    for (int i = 1; i <= W; i++) begin
      check("mul_busy", W'(busy), 1);
      if (i == 10) begin
        ex = 2'b10; func = FN_AND; a = 32'd1; b = 32'd1; start = 1'b1;
      end
      if (i == 11) start = 1'b0;
      @(negedge clk);
    end
    wait_done();
    issue(2'b10, FN_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 4'b1111, W + 1, 1);
    wait_done();

    // divu encoding
`ifdef MULDIV_DIV_EN
    issue(2'b10, FN_DIV, 32'd100, 32'd7, 32'd14, 4'b1110, W + 1, 1);
    wait_done();
    issue(2'b10, FN_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 4'b1110, W + 1, 1);
    wait_done();
    issue(2'b10, FN_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 4'b1110, W + 1, 1);
    wait_done();
`else
    issue(2'b10, FN_DIV, 32'd100, 32'd7, 32'd107, 4'b0010, 1, 1);
    check("divu_as_add_busy", W'(busy), '0);
    wait_done();
    issue(2'b10, FN_DIV, 32'd1234, 32'd0, 32'd1234, 4'b0010, 1, 1);
    wait_done();
`endif

    // back-to-back: start held high across the done cycle
    issue(2'b10, FN_ADD, 32'd1, 32'd2, 32'd3, 4'b0010, 1, 1);
    issue(2'b10, FN_SUB, 32'd10, 32'd3, 32'd7, 4'b0110, 1, 1);
    wait_done();
    @(negedge clk);
    check("done_drop", W'(done), '0);

    // reset in the middle of a mul
    issue(2'b10, FN_MUL, 32'h1234, 32'h5678, '0, 4'b1111, 0, 0);
    repeat (14) @(negedge clk);
    check("mid_busy", W'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", W'(busy), '0);
    check("mrst_done", W'(done), '0);
    check("mrst_result", result, '0);
    check("mrst_ctrl", W'(alu_ctrl), '0);
    check("mrst_zero", W'(zero), 1);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_no_done", W'(done), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised execute-stage ALU with integrated control decode and iterative multiply/divide, the successor to the combinational ALU-control decoder. It decodes the 2-bit EX control field and the 10-bit {funct7,funct3} field into a 4-bit ALU code and executes the operation on WIDTH-bit operands. Single-cycle ops complete in one clock; MUL and DIV run as WIDTH-cycle shift/add sequences. A busy/done handshake lets the pipeline hazard unit stall.

## Interface
- WIDTH, default 32: operand and result width (>= 4).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  operation request; accepted only when busy_o = 0.
- EX_signal_i  in  2  ALUOp: 00 ld/sd, 01 beq, 10 R-type, 11 addi.
- func_i  in  10  {funct7[6:0], funct3[2:0]}; used only when EX_signal_i = 10.
- a_i, b_i  in  WIDTH  operands, sampled at the accept edge only.
- ALUCtrl_o  out  4  registered code of the last accepted op.
- result_o  out  WIDTH  result; held until the next done_o.
- zero_o  out  1  (result_o == 0), same timing as result_o.
- busy_o  out  1  high while MUL/DIV iterates.
- done_o  out  1  one-cycle pulse: result_o/zero_o updated this cycle.

## Operation
- Decode: EX 00/11 -> 0010 add; EX 01 -> 0110 sub; EX 10: func 0000000_111 -> 0000 and, 0000000_110 -> 0001 or, 0000000_000 -> 0010 add, 0100000_000 -> 0110 sub, 0000001_000 -> 1111 mul, 0000001_100 -> 1110 divu. Any other func -> 0010 add.
- States: IDLE, MUL, DIV, DONE.
- IDLE/DONE + start_i: latch a_i, b_i, code into ALUCtrl_o. and/or/add/sub -> compute, go DONE. mul -> MUL, counter = WIDTH. divu -> DIV, counter = WIDTH.
- DONE without start_i -> IDLE. DONE with start_i accepts back-to-back.
- MUL: unsigned shift-add, one multiplier bit per cycle; result_o = low WIDTH bits of product (signed-correct low half). Counter 0 -> DONE.
- DIV: unsigned restoring, one quotient bit per cycle; result_o = quotient. b = 0 -> result all ones, still WIDTH cycles.
- add/sub wrap modulo 2^WIDTH; no overflow flag.
- start_i while busy_o = 1: ignored; operands and code unchanged.
- Reset (any state, incl. mid MUL/DIV): IDLE; result_o = 0, ALUCtrl_o = 0000, zero_o = 1, busy_o = 0, done_o = 0; in-flight op discarded.

## Timing
- Accept edge k. Single-cycle op: done_o = 1 and result_o valid in cycle after k (latency 1); busy_o stays 0.
- MUL/DIV: busy_o = 1 for the WIDTH cycles after k; iterations at edges k+1..k+WIDTH; done_o = 1 in the cycle after edge k+WIDTH (latency WIDTH+1).
- done_o is high exactly one cycle per accepted op; never together with busy_o.
- Inputs other than start_i, EX_signal_i, func_i, a_i, b_i at the accept edge are don't-care.

## Configuration
- MULDIV_DIV_EN defined: DIV state and divider datapath compiled in; func 0000001_100 -> 1110 divu.
- Undefined: no divider hardware; func 0000001_100 decodes as default add (0010), single-cycle, busy_o never set for it.

## Test plan
- WIDTH=32, reset then EX=10, func=0000000_111, a=0xF0F0_F0F0, b=0x0FF0_0FF0 -> next cycle done_o=1, result_o=0x00F0_00F0, ALUCtrl_o=0000, busy_o=0.
- EX=01, a=b=0x1234 -> result_o=0, zero_o=1, ALUCtrl_o=0110 one cycle later.
- mul a=0xFFFF_FFFF, b=3 -> busy_o high 32 cycles, done_o in cycle 33, result_o=0xFFFF_FFFD; start_i pulsed at cycle 10 with other operands ignored.
- MULDIV_DIV_EN: divu a=100, b=7 -> result_o=14 at cycle 33; divu b=0 -> result_o=0xFFFF_FFFF; without macro same func -> add, result_o=107 at cycle 1.
- Back-to-back: start held high across DONE -> second add accepted in DONE cycle, done_o pulses on two consecutive-op boundaries.
- rst_i asserted at cycle 15 of a mul -> next cycle busy_o=0, done_o=0, result_o=0, ALUCtrl_o=0000; no done_o afterwards.
